// File: rtl/uart_register_port.sv
// uart_register_port: UART peripheral on the core's register bus.
// 8N1 transmitter, 2-flop synchronised receiver and a small RX FIFO.
// Read data is registered and appears one clock after the read strobe.
module uart_register_port #(
    parameter logic [15:0] CLKS_PER_BIT    = 16'd50,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          FIFO_ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam logic [6:0] IDX_TX_DATA = 7'd0;
    localparam logic [6:0] IDX_STATUS  = 7'd1;
    localparam logic [6:0] IDX_RX_DATA = 7'd2;
    localparam logic [FIFO_ADDR_WIDTH:0] FIFO_FULL = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // TX state
    tx_state_t r_tx_state;
    logic [15:0] r_tx_timer;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit_cnt;
    logic        r_tx;

    // RX state
    logic        r_rx_meta;
    logic        r_rx_sync;
    rx_state_t   r_rx_state;
    logic [15:0] r_rx_timer;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit_cnt;

    // FIFO state
    logic [7:0]                 r_fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH:0]   r_count;
    logic                       r_overflow;

    logic [15:0] r_read_value;

    logic        w_tx_busy;
    logic        w_tx_write;
    logic        w_rx_tick;
    logic        w_rx_push;
    logic        w_rx_avail;
    logic        w_fifo_full;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_overflow_set;
    logic        w_status_read;
    logic [15:0] w_read_value;
    logic        w_unused;

    assign w_unused = &{1'b0, register_write_value[15:8]};

    assign w_tx_busy  = (r_tx_state != TX_IDLE);
    assign w_tx_write = register_write && (register_index == IDX_TX_DATA);

    // TX FSM: start bit, 8 data bits LSB first, stop bit; each bit CLKS_PER_BIT cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state   <= TX_IDLE;
            r_tx_timer   <= 16'd0;
            r_tx_shift   <= 8'd0;
            r_tx_bit_cnt <= 3'd0;
            r_tx         <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_write) begin
                        r_tx_shift <= register_write_value[7:0];
                        r_tx_timer <= CLKS_PER_BIT - 16'd1;
                        r_tx       <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_timer == 16'd0) begin
                        r_tx         <= r_tx_shift[0];
                        r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit_cnt <= 3'd0;
                        r_tx_timer   <= CLKS_PER_BIT - 16'd1;
                        r_tx_state   <= TX_DATA;
                    end else begin
                        r_tx_timer <= r_tx_timer - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_timer == 16'd0) begin
                        r_tx_timer <= CLKS_PER_BIT - 16'd1;
                        if (r_tx_bit_cnt == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx         <= r_tx_shift[0];
                            r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit_cnt <= r_tx_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_tx_timer <= r_tx_timer - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_timer == 16'd0) begin
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_timer <= r_tx_timer - 16'd1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser on the asynchronous serial input (idles high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_tick = (r_rx_timer == 16'd0);
    // A good stop bit pushes the assembled byte straight into the FIFO
    assign w_rx_push = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;

    // RX FSM: half-bit to the start-bit centre, then one full bit period per sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_timer   <= 16'd0;
            r_rx_shift   <= 8'd0;
            r_rx_bit_cnt <= 3'd0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_timer <= CLKS_PER_BIT >> 1;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_tick) begin
                        if (r_rx_sync) begin
                            r_rx_state <= RX_IDLE;   // too short to be a start bit
                        end else begin
                            r_rx_timer   <= CLKS_PER_BIT - 16'd1;
                            r_rx_bit_cnt <= 3'd0;
                            r_rx_state   <= RX_DATA;
                        end
                    end else begin
                        r_rx_timer <= r_rx_timer - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_timer <= CLKS_PER_BIT - 16'd1;
                        if (r_rx_bit_cnt == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit_cnt <= r_rx_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_rx_timer <= r_rx_timer - 16'd1;
                    end
                end
                RX_STOP: begin
                    // framing errors fall through here without a push
                    if (w_rx_tick) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_timer <= r_rx_timer - 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_rx_avail     = (r_count != '0);
    assign w_fifo_full    = (r_count == FIFO_FULL);
    assign w_pop          = register_read && (register_index == IDX_RX_DATA) && w_rx_avail;
    assign w_push_ok      = w_rx_push && (!w_fifo_full || w_pop);
    assign w_overflow_set = w_rx_push && w_fifo_full && !w_pop;
    assign w_status_read  = register_read && (register_index == IDX_STATUS);

    // FIFO storage, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_mem[r_wr_ptr] <= r_rx_shift;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a new overflow beats the clearing read)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (FIFO_ADDR_WIDTH)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (FIFO_ADDR_WIDTH)'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (FIFO_ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (w_status_read) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Read mux for the currently selected register
    always_comb begin
        w_read_value = 16'd0;
        case (register_index)
            IDX_STATUS:  w_read_value = {13'd0, r_overflow, w_rx_avail, w_tx_busy};
            IDX_RX_DATA: if (w_rx_avail) w_read_value = {8'd0, r_fifo_mem[r_rd_ptr]};
            default:     w_read_value = 16'd0;
        endcase
    end

    // Registered read data, loaded only on a read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_value <= 16'd0;
        end else if (register_read) begin
            r_read_value <= w_read_value;
        end
    end

    assign register_read_value = r_read_value;
    assign uart_tx             = r_tx;

endmodule
